// File: rtl/aes_round_ops.sv
// aes_round_ops: single-cycle AES round primitives (AddRoundKey, ShiftRows, MixColumns, fused round).
// Latency: one cycle from an enabled rising edge to state_out/done; back-to-back issue every cycle.
// Optional macro AES_ROUND_FUSED_EN enables the fused op 11; otherwise op 11 passes state through.
module aes_round_ops (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   op,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] state_out,
  output logic         done
);

  localparam logic [1:0] OP_ARK = 2'b00;
  localparam logic [1:0] OP_SR  = 2'b01;
  localparam logic [1:0] OP_MC  = 2'b10;

  // GF(2^8) multiply-by-two with reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Byte i = r + 4c lives at bits [127-8i -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    shift_rows = o;
  endfunction

  // Each column multiplied by the circulant matrix {02 03 01 01}; 03*x = xtime(x)^x.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    mix_columns = o;
  endfunction

  logic [127:0] result;

  // Select the combinational result for the requested operation.
  always_comb begin
    result = state;
    case (op)
      OP_ARK:  result = state ^ key;
      OP_SR:   result = shift_rows(state);
      OP_MC:   result = mix_columns(state);
      default: begin
`ifdef AES_ROUND_FUSED_EN
        result = mix_columns(shift_rows(state)) ^ key;
`else
        result = state;
`endif
      end
    endcase
  end

  // Register the result on enabled edges; done tracks enable; reset dominates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= enable;
      if (enable) begin
        state_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ops.sv
// Testbench for aes_round_ops: directed known-answer vectors plus randomized back-to-back traffic
// checked against a byte-matrix reference model using generic GF(2^8) multiplication.
// Honours AES_ROUND_FUSED_EN so the op 11 expectation matches the build.
module tb_aes_round_ops;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [1:0]   op;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] state_out;
  logic         done;

  int tests;
  int fails;

  logic [127:0] exp_q;
  logic         exp_done;

  aes_round_ops dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .op        (op),
    .state     (state),
    .key       (key),
    .state_out (state_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef logic [7:0] mat_t [4][4];  // [row][col]

  function automatic mat_t unpack_m(input logic [127:0] s);
    mat_t m;
    for (int i = 0; i < 16; i++) m[i%4][i/4] = s[127-8*i -: 8];
    return m;
  endfunction

  function automatic logic [127:0] pack_m(input mat_t m);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s[127-8*i -: 8] = m[i%4][i/4];
    return s;
  endfunction

  // Russian-peasant multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] s);
    mat_t i_m, o_m;
    i_m = unpack_m(s);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o_m[r][c] = i_m[r][(c + r) % 4];
    return pack_m(o_m);
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    mat_t i_m, o_m;
    logic [127:0] coef;
    logic [7:0]   acc;
    coef = 128'h02030101_01020301_01010203_03010102;
    i_m  = unpack_m(s);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[127-8*(4*r+k) -: 8], i_m[k][c]);
        o_m[r][c] = acc;
      end
    return pack_m(o_m);
  endfunction

  function automatic logic [127:0] model(input logic [1:0] o, input logic [127:0] s, input logic [127:0] k);
    case (o)
      2'b00:   return s ^ k;
      2'b01:   return m_shift(s);
      2'b10:   return m_mix(s);
      default: begin
`ifdef AES_ROUND_FUSED_EN
        return m_mix(m_shift(s)) ^ k;
`else
        return s;
`endif
      end
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic en, input logic [1:0] o, input logic [127:0] s, input logic [127:0] k);
    rst = 1'b1; enable = en; op = o; state = s; key = k;
    tick();
    exp_done = en;
    if (en) exp_q = model(o, s, k);
  endtask

  logic [127:0] fused_kat;
  logic [127:0] rs, rk;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; enable = 1'b1; op = 2'b00;
    state = 128'h0123456789abcdef0123456789abcdef; key = 128'hffff0000ffff0000ffff0000ffff0000;

    // Reset with enable asserted: reset wins.
    @(negedge clk);
    tick();
    chk128("reset_state_out", state_out, 128'h0);
    chk1("reset_done", done, 1'b0);

    // First cycle out of reset with enable low.
    issue(1'b0, 2'b00, 128'h0, 128'h0);
    exp_q = 128'h0;
    chk128("idle_state_out", state_out, 128'h0);
    chk1("idle_done", done, 1'b0);

    // Known-answer: AddRoundKey.
    issue(1'b1, 2'b00, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk128("kat_ark", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk128("kat_ark_model", state_out, exp_q);
    chk1("kat_ark_done", done, 1'b1);

    // Hold for three cycles with enable low while inputs change.
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 2'(i + 1), 128'hdeadbeef_cafef00d_01234567_89abcdef, 128'h5);
      chk128("hold_state_out", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      chk1("hold_done", done, 1'b0);
    end

    // Known-answer: ShiftRows and MixColumns, back to back.
    issue(1'b1, 2'b01, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h0);
    chk128("kat_sr", state_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk128("kat_sr_model", state_out, exp_q);
    chk1("kat_sr_done", done, 1'b1);
    issue(1'b1, 2'b10, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h0);
    chk128("kat_mc", state_out, 128'h046681e5e0cb199a48f8d37a2806264c);
    chk128("kat_mc_model", state_out, exp_q);

    // Known-answer: op 11 (fused round or pass-through depending on build).
`ifdef AES_ROUND_FUSED_EN
    fused_kat = 128'ha49c7ff2689f352b6b5bea43026a5049;
`else
    fused_kat = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
    issue(1'b1, 2'b11, 128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605);
    chk128("kat_op11", state_out, fused_kat);
    chk128("kat_op11_model", state_out, exp_q);
    chk1("kat_op11_done", done, 1'b1);

    // Randomized back-to-back traffic, mostly enabled.
    for (int n = 0; n < 60; n++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      issue(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rs, rk);
      chk128("rand_state_out", state_out, exp_q);
      chk1("rand_done", done, exp_done);
    end

    // Mid-stream reset with an enabled AddRoundKey, then the same op repeated.
    rst = 1'b0; enable = 1'b1; op = 2'b00;
    state = 128'h3243f6a8885a308d313198a2e0370734; key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tick();
    chk128("midreset_state_out", state_out, 128'h0);
    chk1("midreset_done", done, 1'b0);
    issue(1'b1, 2'b00, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk128("post_reset_ark", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk1("post_reset_done", done, 1'b1);
    issue(1'b0, 2'b00, 128'h0, 128'h0);
    chk1("post_reset_done_low", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ops.md
AES_ROUND_OPS -- requirements
Module: aes_round_ops

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL provide: enable  input  1  operation request, sampled each rising edge.
REQ-004 SHALL provide: op  input  2  operation select (00 AddRoundKey, 01 ShiftRows, 10 MixColumns, 11 fused round).
REQ-005 SHALL provide: state  input  128  AES state in.
REQ-006 SHALL provide: key  input  128  round key, used by ops 00 and 11 only.
REQ-007 SHALL provide: state_out  output  128  registered result.
REQ-008 SHALL provide: done  output  1  registered result-valid flag.

Function
REQ-009 SHALL map byte index i = r + 4c (row r, column c, 0..3) to bits [127-8i -: 8], so bits [127:120] are row 0, column 0.
REQ-010 SHALL, for op 00, compute state XOR key bitwise over all 128 bits.
REQ-011 SHALL, for op 01, rotate row r left by r byte positions: out(r,c) = in(r,(c+r) mod 4).
REQ-012 SHALL, for op 10, apply the FIPS-197 MixColumns matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] to each column in GF(2^8), with polynomial 0x11B.
REQ-013 SHALL implement xtime(b) as (b<<1) XOR (b[7] ? 0x1B : 0x00), truncated to 8 bits.
REQ-014 SHALL, when enable=1 at a rising edge, load state_out with the selected result; latency is exactly 1 cycle.
REQ-015 SHALL hold state_out unchanged while enable=0.
REQ-016 SHALL register done <= enable every cycle, so done is high exactly in the cycles after enabled edges.
REQ-017 SHALL support back-to-back operations: a new op or operand may be applied every cycle, with no bubble.
REQ-018 SHALL contain no state other than state_out and done; there is no FSM.
REQ-019 SHALL make a mid-operation reset (rst=0 on an enabled edge) win over enable.

Reset
REQ-020 SHALL, on a rising edge with rst=0, set state_out to 128'h0 and done to 0, regardless of enable or op.
REQ-021 SHALL resume normal operation on the first rising edge with rst=1.

Configuration
REQ-022 SHALL gate the fused-round datapath with macro AES_ROUND_FUSED_EN.
REQ-023 SHALL, with AES_ROUND_FUSED_EN defined, compute op 11 as AddRoundKey(MixColumns(ShiftRows(state)), key) in one cycle.
REQ-024 SHALL, without AES_ROUND_FUSED_EN, treat op 11 as pass-through (state_out <= state). done behaves per REQ-016, and no fused logic is synthesized.

Verification
REQ-025 SHALL cover op 00: state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> next cycle state_out=193de3bea0f4e22b9ac68d2ae9f84808, done=1.
REQ-026 SHALL cover op 01: state=d42711aee0bf98f1b8b45de51e415230 -> state_out=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-027 SHALL cover op 10: state=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out=046681e5e0cb199a48f8d37a2806264c.
REQ-028 SHALL cover op 11 with macro defined: state=d42711aee0bf98f1b8b45de51e415230, key=a0fafe1788542cb123a339392a6c7605 -> state_out=a49c7ff2689f352b6b5bea43026a5049. Without the macro -> state_out equals the input state.
REQ-029 SHALL cover hold: enable=0 for 3 cycles after REQ-025 -> state_out stays 193de3be..., done=0.
REQ-030 SHALL cover reset: rst=0 with enable=1, op=00 -> next edge state_out=0, done=0. Then rst=1 with the op repeated -> result appears one cycle later.
